// File: rtl/classifier_arbiter.sv
// rtl/classifier_arbiter.sv - round-robin arbiter and job sequencer for the shared classifier
// Optional job watchdog enabled by defining CLS_ARB_TIMEOUT_EN.
module classifier_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [1:0]         rsp_class,
  output logic               rsp_err,
  output logic               busy,
  output logic               cls_start,
  input  logic               cls_ready,
  input  logic               cls_done,
  input  logic [1:0]         cls_class
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
    $error("classifier_arbiter: NUM_REQ must be in 1..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("classifier_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   winner_q, winner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_class_q, rsp_class_d;
  logic               cls_start_q, cls_start_d;
  logic               busy_q, busy_d;
  logic               timeout;

  logic [PTR_W-1:0]   pick;
  logic               found;
  logic [NUM_REQ-1:0] req_sh;
  int                 idx;

`ifdef CLS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_err_q, rsp_err_d;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Search upward from ptr with explicit wrap, since NUM_REQ need not be a power of two.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    idx    = 0;
    req_sh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    rsp_valid_d = '0;
    rsp_class_d = rsp_class_q;
    cls_start_d = cls_start_q;
`ifdef CLS_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found && cls_ready) begin
          state_d     = RUN;
          winner_d    = pick;
          grant_d     = NUM_REQ'(1) << pick;
          cls_start_d = 1'b1;
`ifdef CLS_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      RUN: begin
`ifdef CLS_ARB_TIMEOUT_EN
        if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        // A done arriving on the timeout cycle still counts as a good result.
        if (cls_done) begin
          state_d     = RESP;
          rsp_valid_d = grant_q;
          rsp_class_d = cls_class;
          cls_start_d = 1'b0;
`ifdef CLS_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end else if (timeout) begin
          state_d     = RESP;
          rsp_valid_d = grant_q;
          rsp_class_d = 2'd0;
          cls_start_d = 1'b0;
`ifdef CLS_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b1;
`endif
        end
      end
      RESP: begin
        state_d     = IDLE;
        grant_d     = '0;
        rsp_class_d = 2'd0;
`ifdef CLS_ARB_TIMEOUT_EN
        rsp_err_d   = 1'b0;
`endif
        if (winner_q == PTR_W'(NUM_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = winner_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_class_q <= 2'd0;
      cls_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CLS_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_class_q <= rsp_class_d;
      cls_start_q <= cls_start_d;
      busy_q      <= busy_d;
`ifdef CLS_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_class = rsp_class_q;
  assign busy      = busy_q;
  assign cls_start = cls_start_q;
`ifdef CLS_ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_classifier_arbiter.sv
// tb/tb_classifier_arbiter.sv - scoreboard bench for classifier_arbiter
// Watchdog scenarios follow CLS_ARB_TIMEOUT_EN.
module tb_classifier_arbiter;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cls_ready;
  logic [1:0] req_a, grant_a, rsp_valid_a, rsp_class_a, class_a;
  logic       rsp_err_a, busy_a, start_a, done_a;
  logic [2:0] req_b, grant_b, rsp_valid_b;
  logic [1:0] rsp_class_b, class_b;
  logic       rsp_err_b, busy_b, start_b, done_b;

  typedef struct {
    logic [2:0] onehot;
    logic [1:0] cls;
    logic       err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   checks = 0;
  int   failures = 0;
  int   ptr_a = 0;
  int   ptr_b = 0;

  always #5 clk = ~clk;

  classifier_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(T)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .grant(grant_a), .rsp_valid(rsp_valid_a),
    .rsp_class(rsp_class_a), .rsp_err(rsp_err_a), .busy(busy_a), .cls_start(start_a),
    .cls_ready(cls_ready), .cls_done(done_a), .cls_class(class_a)
  );

  classifier_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(T)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .grant(grant_b), .rsp_valid(rsp_valid_b),
    .rsp_class(rsp_class_b), .rsp_err(rsp_err_b), .busy(busy_b), .cls_start(start_b),
    .cls_ready(cls_ready), .cls_done(done_b), .cls_class(class_b)
  );

  function automatic int winner(input logic [7:0] r, input int p, input int n);
    int k;
    for (int i = 0; i < n; i++) begin
      k = (p + i) % n;
      if (((r >> k) & 8'd1) != 8'd0) return k;
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid_a !== 2'b00) begin
      checks++;
      if (q_a.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected_a got rsp_valid=%b exp none", rsp_valid_a);
      end else begin
        e_a = q_a.pop_front();
        if ({rsp_valid_a, rsp_class_a, rsp_err_a} !== {e_a.onehot[1:0], e_a.cls, e_a.err}) begin
          failures++;
          $display("FAIL rsp_a got valid=%b class=%0d err=%b exp valid=%b class=%0d err=%b",
                   rsp_valid_a, rsp_class_a, rsp_err_a, e_a.onehot[1:0], e_a.cls, e_a.err);
        end
      end
    end
    if (rsp_valid_b !== 3'b000) begin
      checks++;
      if (q_b.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected_b got rsp_valid=%b exp none", rsp_valid_b);
      end else begin
        e_b = q_b.pop_front();
        if ({rsp_valid_b, rsp_class_b, rsp_err_b} !== {e_b.onehot, e_b.cls, e_b.err}) begin
          failures++;
          $display("FAIL rsp_b got valid=%b class=%0d err=%b exp valid=%b class=%0d err=%b",
                   rsp_valid_b, rsp_class_b, rsp_err_b, e_b.onehot, e_b.cls, e_b.err);
        end
      end
    end
  end

  task automatic wait_grant_a(output int w);
    int n;
    n = 0;
    @(negedge clk);
    while (grant_a === 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    w = winner({6'b0, req_a}, ptr_a, 2);
    checks++;
    if (grant_a !== 2'(1 << w)) begin
      failures++;
      $display("FAIL grant_a got=%b exp=%b", grant_a, 2'(1 << w));
    end
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (q_a.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_a.size() != 0) begin
      failures++;
      $display("FAIL rsp_a_missing got pending=%0d exp=0", q_a.size());
      q_a.delete();
    end
  endtask

  task automatic run_job_a(input logic [1:0] r, input logic [1:0] c, input int delay, input bit drop);
    int w;
    req_a = r;
    cls_ready = 1'b1;
    wait_grant_a(w);
    q_a.push_back('{3'(1 << w), c, 1'b0});
    if (drop) req_a = 2'b00;
    repeat (delay) @(negedge clk);
    done_a = 1'b1;
    class_a = c;
    @(negedge clk);
    done_a = 1'b0;
    ptr_a = (w + 1) % 2;
    drain_a();
  endtask

  task automatic run_job_b(input logic [2:0] r, input logic [1:0] c);
    int n, w;
    req_b = r;
    n = 0;
    @(negedge clk);
    while (grant_b === 3'b000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    w = winner({5'b0, r}, ptr_b, 3);
    checks++;
    if (grant_b !== 3'(1 << w)) begin
      failures++;
      $display("FAIL grant_b got=%b exp=%b", grant_b, 3'(1 << w));
    end
    q_b.push_back('{3'(1 << w), c, 1'b0});
    done_b = 1'b1;
    class_b = c;
    @(negedge clk);
    done_b = 1'b0;
    ptr_b = (w + 1) % 3;
    n = 0;
    while (q_b.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_b.size() != 0) begin
      failures++;
      $display("FAIL rsp_b_missing got pending=%0d exp=0", q_b.size());
      q_b.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ptr_a = 0;
    ptr_b = 0;
    @(negedge clk);
    checks++;
    if ({grant_a, rsp_valid_a, rsp_class_a, rsp_err_a, busy_a, start_a} !== 9'd0) begin
      failures++;
      $display("FAIL reset_a got grant=%b valid=%b class=%0d err=%b busy=%b start=%b exp all 0",
               grant_a, rsp_valid_a, rsp_class_a, rsp_err_a, busy_a, start_a);
    end
    checks++;
    if ({grant_b, rsp_valid_b, rsp_class_b, rsp_err_b, busy_b, start_b} !== 11'd0) begin
      failures++;
      $display("FAIL reset_b got grant=%b valid=%b busy=%b start=%b exp all 0",
               grant_b, rsp_valid_b, busy_b, start_b);
    end
    req_a = 2'b01;
    cls_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({grant_a, start_a, busy_a} !== 4'b0111) begin
      failures++;
      $display("FAIL first_grant got grant=%b start=%b busy=%b exp 01 1 1", grant_a, start_a, busy_a);
    end
    q_a.push_back('{3'b001, 2'd2, 1'b0});
    done_a = 1'b1;
    class_a = 2'd2;
    @(negedge clk);
    done_a = 1'b0;
    checks++;
    if (start_a !== 1'b0 || grant_a !== 2'b01) begin
      failures++;
      $display("FAIL resp_cycle got start=%b grant=%b exp 0 01", start_a, grant_a);
    end
    req_a = 2'b00;
    ptr_a = 1;
    @(negedge clk);
    checks++;
    if (grant_a !== 2'b00 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL release got grant=%b busy=%b exp 00 0", grant_a, busy_a);
    end
    drain_a();
  endtask

  task automatic test_round_robin();
    run_job_a(2'b11, 2'd1, 0, 1'b0);
    run_job_a(2'b11, 2'd3, 2, 1'b0);
    run_job_a(2'b11, 2'd0, 1, 1'b0);
    run_job_a(2'b11, 2'd2, 4, 1'b0);
    req_a = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stall();
    req_a = 2'b01;
    cls_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (grant_a !== 2'b00 || busy_a !== 1'b0) begin
        failures++;
        $display("FAIL stall cycle=%0d got grant=%b busy=%b exp 00 0", i, grant_a, busy_a);
      end
    end
    cls_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant_a !== 2'b01) begin
      failures++;
      $display("FAIL stall_release got grant=%b exp=01", grant_a);
    end
    q_a.push_back('{3'b001, 2'd3, 1'b0});
    done_a = 1'b1;
    class_a = 2'd3;
    @(negedge clk);
    done_a = 1'b0;
    req_a = 2'b00;
    ptr_a = 1;
    drain_a();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, w;
    req_a = 2'b01;
    wait_grant_a(w);
`ifdef CLS_ARB_TIMEOUT_EN
    q_a.push_back('{3'(1 << w), 2'd0, 1'b1});
    class_a = 2'd3;
    n = 0;
    while (rsp_valid_a === 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != T) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d", n, T);
    end
`else
    repeat (20) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || start_a !== 1'b1 || rsp_valid_a !== 2'b00) begin
      failures++;
      $display("FAIL no_watchdog got busy=%b start=%b valid=%b exp 1 1 00", busy_a, start_a, rsp_valid_a);
    end
    q_a.push_back('{3'(1 << w), 2'd2, 1'b0});
    done_a = 1'b1;
    class_a = 2'd2;
    @(negedge clk);
    done_a = 1'b0;
`endif
    req_a = 2'b00;
    ptr_a = (w + 1) % 2;
    drain_a();
    repeat (2) @(negedge clk);
    req_a = 2'b01;
    wait_grant_a(w);
    repeat (T - 1) @(negedge clk);
    q_a.push_back('{3'(1 << w), 2'd1, 1'b0});
    done_a = 1'b1;
    class_a = 2'd1;
    @(negedge clk);
    done_a = 1'b0;
    checks++;
    if (rsp_valid_a !== 2'(1 << w)) begin
      failures++;
      $display("FAIL done_at_limit got valid=%b exp=%b", rsp_valid_a, 2'(1 << w));
    end
    req_a = 2'b00;
    ptr_a = (w + 1) % 2;
    drain_a();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_owner_drop();
    run_job_a(2'b10, 2'd3, 2, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_done_in_idle();
    req_a = 2'b00;
    done_a = 1'b1;
    class_a = 2'd2;
    @(negedge clk);
    done_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (grant_a !== 2'b00 || busy_a !== 1'b0 || start_a !== 1'b0) begin
      failures++;
      $display("FAIL done_in_idle got grant=%b busy=%b start=%b exp 00 0 0", grant_a, busy_a, start_a);
    end
  endtask

  task automatic test_reset_mid_job();
    int w;
    run_job_a(2'b01, 2'd1, 0, 1'b0);
    req_a = 2'b00;
    repeat (2) @(negedge clk);
    req_a = 2'b01;
    wait_grant_a(w);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req_a = 2'b00;
    @(negedge clk);
    checks++;
    if ({grant_a, rsp_valid_a, busy_a, start_a, rsp_err_a} !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid_job got grant=%b valid=%b busy=%b start=%b exp all 0",
               grant_a, rsp_valid_a, busy_a, start_a);
    end
    rst = 1'b0;
    ptr_a = 0;
    ptr_b = 0;
    run_job_a(2'b11, 2'd2, 1, 1'b0);
    req_a = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin_3();
    run_job_b(3'b101, 2'd1);
    run_job_b(3'b101, 2'd2);
    run_job_b(3'b101, 2'd3);
    req_b = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cls_ready = 1'b0;
    req_a = 2'b00;
    req_b = 3'b000;
    done_a = 1'b0;
    done_b = 1'b0;
    class_a = 2'd0;
    class_b = 2'd0;
    test_reset();
    test_round_robin();
    test_stall();
    test_timeout();
    test_owner_drop();
    test_done_in_idle();
    test_reset_mid_job();
    test_round_robin_3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/classifier_arbiter.md
# classifier_arbiter

Round-robin arbiter and job sequencer that shares the single transformer classifier among NUM_REQ requesters, e.g. CPU NEUR issue, a DMA pixel engine and a debug port. It sits between the requesters and the classifier's start/ready/done handshake. It grants one requester at a time and drives the classifier start level for the duration of the job. It returns the class result, or a timeout error, to the granted requester only.

## Interface
Parameters:
- NUM_REQ, 2: number of requesters, legal range 1..8.
- TIMEOUT_CYCLES, 4096: watchdog limit in cycles per job, ≥ 2. Used only with CLS_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held until its rsp_valid.
- grant  out  NUM_REQ  one-hot; current owner of the classifier.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse to the owner at job end.
- rsp_class  out  2  class result; valid while any rsp_valid bit is high.
- rsp_err  out  1  1 = job ended by watchdog; valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- cls_start  out  1  level start to the classifier.
- cls_ready  in  1  classifier idle and able to accept start.
- cls_done  in  1  classifier result valid.
- cls_class  in  2  classifier result.

## Operation
- State machine has three states: IDLE, RUN and RESP. Reset puts it in IDLE.
- IDLE: if |req and cls_ready, select the winner and go to RUN. Otherwise stay in IDLE.
  - The winner is the first set req bit searching upward from ptr, wrapping modulo NUM_REQ.
  - On entry to RUN: register grant = one-hot winner, set cls_start = 1, clear the timeout counter.
- RUN:
  - cls_start is held at 1.
  - The counter increments every cycle.
  - On cls_done: capture cls_class, set err = 0, go to RESP.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: set err = 1, set rsp_class = 0, go to RESP.
- RESP:
  - cls_start = 0.
  - rsp_valid = grant for exactly one cycle, with rsp_class and rsp_err.
  - ptr <= (winner+1) mod NUM_REQ.
  - grant is cleared on exit, then return to IDLE.
- Arithmetic:
  - ptr is ceil(log2(NUM_REQ)) bits; wrap is explicit (NUM_REQ need not be a power of 2).
  - Counter width is ceil(log2(TIMEOUT_CYCLES+1)); it saturates and never wraps.
- Boundary conditions:
  - **req held without cls_ready:** no grant is issued; the block stays in IDLE.
  - **Owner drops req in RUN:** the job still completes and rsp_valid is still pulsed. There is no abort.
  - **cls_done and timeout in the same cycle:** done wins, err = 0.
  - **cls_done in IDLE or RESP:** ignored.
  - **Single pending requester:** it is re-granted each round, with no starvation of others once they assert.
  - **NUM_REQ = 1:** ptr is constant 0.
  - **rst mid-job:** next cycle state = IDLE, all outputs 0, ptr = 0, no response issued.
- Reset values: grant = 0, rsp_valid = 0, rsp_class = 0, rsp_err = 0, busy = 0, cls_start = 0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- req and cls_ready sampled high at edge N → grant, busy and cls_start high after edge N+1.
- cls_done sampled high at edge M → rsp_valid pulse and cls_start = 0 after edge M+1; grant, busy = 0 after edge M+2.
- Minimum grant-to-grant spacing is 3 cycles after cls_done.
- Watchdog: cls_start rises at edge S; with no cls_done, rsp_valid with err = 1 appears after edge S+TIMEOUT_CYCLES.
- Single-requester throughput: the block adds 3 cycles of overhead per classification.

## Configuration
- CLS_ARB_TIMEOUT_EN defined: the watchdog counter is built and RUN can exit on timeout with rsp_err = 1.
- CLS_ARB_TIMEOUT_EN undefined:
  - The counter is removed and RUN exits only on cls_done.
  - rsp_err is tied to 0 and TIMEOUT_CYCLES is ignored.
  - All other timing is identical.

## Test plan
- Reset then idle: after rst, check all outputs 0. Assert req = 2'b01 with cls_ready = 1 → grant = 01 and cls_start = 1 one cycle later. cls_done with cls_class = 2 → rsp_valid = 01, rsp_class = 2, rsp_err = 0.
- Round-robin: req = 2'b11 held for 4 jobs → grants alternate 01, 10, 01, 10 with ptr starting at 0. NUM_REQ = 3 with req = 3'b101 → grants 001, 100, 001.
- Stall: req = 01 with cls_ready = 0 for 10 cycles → grant stays 0 and busy stays 0. cls_ready → 1 → grant = 01 on the next cycle.
- Timeout (macro on, TIMEOUT_CYCLES = 8): never assert cls_done → rsp_valid after 8 RUN cycles, rsp_err = 1, rsp_class = 0. Repeat with cls_done in the 8th cycle → rsp_err = 0.
- Reset mid-job: assert rst 3 cycles into RUN → cls_start = 0, grant = 0 next cycle, no rsp_valid pulse. A subsequent req = 10 is granted first because ptr = 0 and bit 0 is clear.
- Owner drops req during RUN → rsp_valid still pulses to that owner. A cls_done pulse in IDLE → no response.
